// File: rtl/div32_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference only if no borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] d_inv;
  logic [WIDTH:0] diff;
  logic           unused_r_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero before the shift and can be dropped.
  assign unused_r_msb = r[WIDTH];
  assign r_sh         = {r[WIDTH-1:0], q_msb};

  assign d_inv  = ~{1'b0, d};
  assign diff   = r_sh + d_inv + (WIDTH+1)'(1);

  assign q_bit  = ~diff[WIDTH];
  assign r_next = q_bit ? diff : r_sh;

endmodule

// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider with valid/ready handshakes.
// Optional signed mode is enabled by defining DIV32_SIGNED_EN.
module div32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic             dz_reg;

  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic             do_prep;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

`ifdef DIV32_SIGNED_EN
  logic prep;
  logic q_neg;
  logic r_neg;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  assign do_prep = prep;

  always_comb begin
    q_out = q_neg ? negate(q_reg) : q_reg;
    r_out = r_neg ? negate(r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
  end
`else
  assign do_prep = 1'b0;

  always_comb begin
    q_out = q_reg;
    r_out = r_reg[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      dz_reg      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
`ifdef DIV32_SIGNED_EN
      prep        <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            d_reg    <= divisor;
            cnt      <= CNT_W'(WIDTH);
            if (divisor == '0) begin
              // Divide-by-zero results are staged directly in Q/R so DONE
              // presents them exactly like a computed result.
              q_reg  <= WIDTH'(DIV0_QUOTIENT);
              r_reg  <= {1'b0, dividend};
              dz_reg <= 1'b1;
              state  <= DONE;
`ifdef DIV32_SIGNED_EN
              prep   <= 1'b0;
              q_neg  <= 1'b0;
              r_neg  <= 1'b0;
`endif
            end else begin
              q_reg  <= dividend;
              r_reg  <= '0;
              dz_reg <= 1'b0;
              state  <= CALC;
`ifdef DIV32_SIGNED_EN
              prep   <= signed_op;
              q_neg  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg  <= signed_op & dividend[WIDTH-1];
`endif
            end
          end
        end

        CALC: begin
          if (do_prep) begin
`ifdef DIV32_SIGNED_EN
            prep <= 1'b0;
            if (q_reg[WIDTH-1]) q_reg <= negate(q_reg);
            if (d_reg[WIDTH-1]) d_reg <= negate(d_reg);
`endif
          end else begin
            r_reg <= r_next;
            q_reg <= {q_reg[WIDTH-2:0], q_bit};
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= DONE;
          end
        end

        DONE: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= q_out;
            remainder   <= r_out;
            div_by_zero <= dz_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq (signed vectors when
// DIV32_SIGNED_EN is defined).
module tb_div32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
`ifdef DIV32_SIGNED_EN
  logic        signed_op;
`endif

  int vectors = 0;
  int miscompares = 0;

  div32_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV32_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus helpers: launch one operation and count edges to out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
`ifdef DIV32_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hs: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    vectors++;
    if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got q=%h r=%h dz=%b expected 0/0/0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_op(32'd100, 32'd7, lat);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 33", lat);
    end
    vectors++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b expected 14/2/0", quotient, remainder, div_by_zero);
    end
    consume();
    do_op(32'h8000_0000, 32'd3, lat);
    vectors++;
    if (quotient !== 32'h2AAA_AAAA || remainder !== 32'd2) begin
      miscompares++;
      $display("FAIL basic_msb_3: got q=%h r=%h expected 2aaaaaaa/2", quotient, remainder);
    end
    consume();
  endtask

  task automatic test_boundary();
    int lat;
    do_op(32'hFFFF_FFFF, 32'd1, lat);
    vectors++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL bound_max_1: got q=%h r=%h dz=%b expected ffffffff/0/0", quotient, remainder, div_by_zero);
    end
    consume();
    do_op(32'd5, 32'd9, lat);
    vectors++;
    if (quotient !== 32'd0 || remainder !== 32'd5) begin
      miscompares++;
      $display("FAIL bound_5_9: got q=%0d r=%0d expected 0/5", quotient, remainder);
    end
    consume();
  endtask

  task automatic test_div_by_zero();
    int lat;
    do_op(32'h0000_1234, 32'd0, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL div0_latency: got %0d expected 1", lat);
    end
    vectors++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0000_1234 || div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL div0_result: got q=%h r=%h dz=%b expected ffffffff/1234/1", quotient, remainder, div_by_zero);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'd1000, 32'd10, lat);
    for (int i = 0; i < 10; i++) begin
      // New operands offered while a result is pending must be ignored.
      @(negedge clk);
      in_valid = (i == 3);
      dividend = 32'd77;
      divisor  = 32'd7;
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd100 || remainder !== 32'd0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got ov=%b ir=%b q=%0d r=%0d expected 1/0/100/0",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    in_valid = 1'b0;
    consume();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: got ov=%b ir=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd77;
    divisor  = 32'd7;
    in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reset: got ov=%b ir=%b expected 0/1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_discard: got out_valid seen=%b expected 0", seen);
    end
    do_op(32'd81, 32'd9, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'd9 || remainder !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_next_81_9: got lat=%0d q=%0d r=%0d expected 33/9/0", lat, quotient, remainder);
    end
    consume();
  endtask

`ifdef DIV32_SIGNED_EN
  task automatic test_signed();
    int lat;
    signed_op = 1'b1;
    do_op(32'hFFFF_FFF9, 32'd2, lat);
    vectors++;
    if (lat !== 34) begin
      miscompares++;
      $display("FAIL signed_latency: got %0d expected 34", lat);
    end
    vectors++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL signed_m7_2: got q=%h r=%h dz=%b expected fffffffd/ffffffff/0", quotient, remainder, div_by_zero);
    end
    consume();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
    vectors++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL signed_overflow: got q=%h r=%h dz=%b expected 80000000/0/0", quotient, remainder, div_by_zero);
    end
    consume();
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_by_zero();
    test_backpressure();
    test_abort();
`ifdef DIV32_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
